// File: rtl/serial_block_io.sv
// -----------------------------------------------------------------------------
// serial_block_io
//   Serial-to-parallel receiver and parallel-to-serial transmitter sharing one
//   clock. The two directions are independent and may run at the same time.
//
//   RX: one bit is taken per cycle while rx_en is high. After BLOCK_W accepted
//       bits the finished word is copied to rx_block and rx_valid rises on the
//       following cycle. rx_valid stays high until rx_ack. A block that
//       completes while an earlier one is still unacknowledged replaces it and
//       sets the sticky rx_overrun flag.
//   TX: tx_load in IDLE captures tx_block. The word is then sent one bit per
//       cycle for BLOCK_W cycles, and tx_done pulses in the first IDLE cycle.
//
//   Ports
//     sclk        clock, rising edge
//     n_rst       asynchronous active-low reset
//     clear       synchronous abort of RX and TX (rx_block is kept)
//     rx_en       serial bit valid
//     data_in     serial data in
//     rx_block    last completed block
//     rx_valid    rx_block holds an unacknowledged block
//     rx_ack      consumer takes rx_block
//     rx_overrun  sticky: a block was overwritten before being acknowledged
//     tx_load     request to send tx_block
//     tx_block    parallel word to send
//     tx_ready    TX idle, tx_load will be accepted
//     data_out    serial data out, 0 while idle
//     tx_active   TX shifting
//     tx_done     one-cycle pulse in the first idle cycle after a block
//
//   MSB_FIRST selects the bit order of both directions.
// -----------------------------------------------------------------------------
module serial_block_io #(
    parameter int BLOCK_W   = 64,
    parameter int CNT_W     = 7,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               sclk,
    input  logic               n_rst,
    input  logic               clear,
    input  logic               rx_en,
    input  logic               data_in,
    output logic [BLOCK_W-1:0] rx_block,
    output logic               rx_valid,
    input  logic               rx_ack,
    output logic               rx_overrun,
    input  logic               tx_load,
    input  logic [BLOCK_W-1:0] tx_block,
    output logic               tx_ready,
    output logic               data_out,
    output logic               tx_active,
    output logic               tx_done
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    // Bit that leaves the TX shifter first for the configured order.
    function automatic logic lead_bit(input logic [BLOCK_W-1:0] word);
        logic bit_v;
        if (MSB_FIRST) begin
            bit_v = word[BLOCK_W-1];
        end else begin
            bit_v = word[0];
        end
        return bit_v;
    endfunction

    // RX state
    logic [BLOCK_W-1:0] rx_shift_r;
    logic [CNT_W-1:0]   rx_cnt_r;
    logic [BLOCK_W-1:0] rx_block_r;
    logic               rx_valid_r;
    logic               rx_overrun_r;
    logic [BLOCK_W-1:0] rx_next_s;
    logic               rx_last_s;

    // TX state
    tx_state_t          tx_state_r;
    logic [BLOCK_W-1:0] tx_shift_r;
    logic [CNT_W-1:0]   tx_cnt_r;
    logic               data_out_r;
    logic               tx_ready_r;
    logic               tx_active_r;
    logic               tx_done_r;
    logic [BLOCK_W-1:0] tx_adv_s;

    // RX shifter input: new bit enters opposite to the end the first bit ends up in.
    always_comb begin
        rx_next_s = {BLOCK_W{1'b0}};
        if (MSB_FIRST) begin
            rx_next_s = {rx_shift_r[BLOCK_W-2:0], data_in};
        end else begin
            rx_next_s = {data_in, rx_shift_r[BLOCK_W-1:1]};
        end
    end

    // Block completes on the accepted bit that finds the counter at its last value.
    always_comb begin
        rx_last_s = 1'b0;
        if (rx_en && (rx_cnt_r == LAST_CNT)) begin
            rx_last_s = 1'b1;
        end else begin
            rx_last_s = 1'b0;
        end
    end

    // TX shifter advanced by one bit, the vacated end filled with zero.
    always_comb begin
        tx_adv_s = {BLOCK_W{1'b0}};
        if (MSB_FIRST) begin
            tx_adv_s = {tx_shift_r[BLOCK_W-2:0], 1'b0};
        end else begin
            tx_adv_s = {1'b0, tx_shift_r[BLOCK_W-1:1]};
        end
    end

    // RX assembly, hand-off register and overrun tracking.
    always_ff @(posedge sclk or negedge n_rst) begin
        if (!n_rst) begin
            rx_shift_r   <= {BLOCK_W{1'b0}};
            rx_cnt_r     <= {CNT_W{1'b0}};
            rx_block_r   <= {BLOCK_W{1'b0}};
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else if (clear) begin
            // rx_block_r deliberately kept so a consumer can still read it.
            rx_shift_r   <= {BLOCK_W{1'b0}};
            rx_cnt_r     <= {CNT_W{1'b0}};
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
        end else begin
            if (rx_en) begin
                rx_shift_r <= rx_next_s;
                rx_cnt_r   <= rx_last_s ? {CNT_W{1'b0}} : (rx_cnt_r + CNT_ONE);
            end
            if (rx_last_s) begin
                rx_block_r <= rx_next_s;
                rx_valid_r <= 1'b1;
                // A coincident ack consumes the old block, so no loss occurs.
                if (rx_valid_r && !rx_ack) begin
                    rx_overrun_r <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid_r <= 1'b0;
            end
        end
    end

    // TX state machine with registered serial and status outputs.
    always_ff @(posedge sclk or negedge n_rst) begin
        if (!n_rst) begin
            tx_state_r  <= TX_IDLE;
            tx_shift_r  <= {BLOCK_W{1'b0}};
            tx_cnt_r    <= {CNT_W{1'b0}};
            data_out_r  <= 1'b0;
            tx_ready_r  <= 1'b1;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
        end else if (clear) begin
            tx_state_r  <= TX_IDLE;
            tx_shift_r  <= {BLOCK_W{1'b0}};
            tx_cnt_r    <= {CNT_W{1'b0}};
            data_out_r  <= 1'b0;
            tx_ready_r  <= 1'b1;
            tx_active_r <= 1'b0;
            tx_done_r   <= 1'b0;
        end else begin
            case (tx_state_r)
                TX_IDLE: begin
                    tx_done_r <= 1'b0;
                    if (tx_load) begin
                        // First bit is driven in the very first SHIFT cycle.
                        tx_state_r  <= TX_SHIFT;
                        tx_shift_r  <= tx_block;
                        tx_cnt_r    <= {CNT_W{1'b0}};
                        data_out_r  <= lead_bit(tx_block);
                        tx_ready_r  <= 1'b0;
                        tx_active_r <= 1'b1;
                    end
                end
                TX_SHIFT: begin
                    if (tx_cnt_r == LAST_CNT) begin
                        tx_state_r  <= TX_IDLE;
                        tx_shift_r  <= {BLOCK_W{1'b0}};
                        tx_cnt_r    <= {CNT_W{1'b0}};
                        data_out_r  <= 1'b0;
                        tx_ready_r  <= 1'b1;
                        tx_active_r <= 1'b0;
                        tx_done_r   <= 1'b1;
                    end else begin
                        tx_shift_r <= tx_adv_s;
                        tx_cnt_r   <= tx_cnt_r + CNT_ONE;
                        data_out_r <= lead_bit(tx_adv_s);
                    end
                end
                default: begin
                    tx_state_r  <= TX_IDLE;
                    tx_shift_r  <= {BLOCK_W{1'b0}};
                    tx_cnt_r    <= {CNT_W{1'b0}};
                    data_out_r  <= 1'b0;
                    tx_ready_r  <= 1'b1;
                    tx_active_r <= 1'b0;
                    tx_done_r   <= 1'b0;
                end
            endcase
        end
    end

    assign rx_block   = rx_block_r;
    assign rx_valid   = rx_valid_r;
    assign rx_overrun = rx_overrun_r;
    assign tx_ready   = tx_ready_r;
    assign data_out   = data_out_r;
    assign tx_active  = tx_active_r;
    assign tx_done    = tx_done_r;

endmodule

// File: tb/tb_serial_block_io.sv
// -----------------------------------------------------------------------------
// tb_serial_block_io
//   Three instances share one stimulus: a = 64-bit MSB first, b = 64-bit LSB
//   first, c = 8-bit MSB first. Directed scenarios plus a randomized run
//   checked against a bit-position model of the serial protocol.
// -----------------------------------------------------------------------------
module tb_serial_block_io;

    logic        sclk = 1'b0;
    logic        n_rst, clear, rx_en, data_in, rx_ack, tx_load;
    logic [63:0] tx_block;

    logic [63:0] rx_block_a, rx_block_b;
    logic [7:0]  rx_block_c;
    logic        rx_valid_a, rx_overrun_a, tx_ready_a, data_out_a, tx_active_a, tx_done_a;
    logic        rx_valid_b, rx_overrun_b, tx_ready_b, data_out_b, tx_active_b, tx_done_b;
    logic        rx_valid_c, rx_overrun_c, tx_ready_c, data_out_c, tx_active_c, tx_done_c;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    serial_block_io #(.BLOCK_W(64), .CNT_W(7), .MSB_FIRST(1'b1)) dut_a (
        .sclk(sclk), .n_rst(n_rst), .clear(clear), .rx_en(rx_en), .data_in(data_in),
        .rx_block(rx_block_a), .rx_valid(rx_valid_a), .rx_ack(rx_ack), .rx_overrun(rx_overrun_a),
        .tx_load(tx_load), .tx_block(tx_block), .tx_ready(tx_ready_a), .data_out(data_out_a),
        .tx_active(tx_active_a), .tx_done(tx_done_a));

    serial_block_io #(.BLOCK_W(64), .CNT_W(7), .MSB_FIRST(1'b0)) dut_b (
        .sclk(sclk), .n_rst(n_rst), .clear(clear), .rx_en(rx_en), .data_in(data_in),
        .rx_block(rx_block_b), .rx_valid(rx_valid_b), .rx_ack(rx_ack), .rx_overrun(rx_overrun_b),
        .tx_load(tx_load), .tx_block(tx_block), .tx_ready(tx_ready_b), .data_out(data_out_b),
        .tx_active(tx_active_b), .tx_done(tx_done_b));

    serial_block_io #(.BLOCK_W(8), .CNT_W(4), .MSB_FIRST(1'b1)) dut_c (
        .sclk(sclk), .n_rst(n_rst), .clear(clear), .rx_en(rx_en), .data_in(data_in),
        .rx_block(rx_block_c), .rx_valid(rx_valid_c), .rx_ack(rx_ack), .rx_overrun(rx_overrun_c),
        .tx_load(tx_load), .tx_block(tx_block[7:0]), .tx_ready(tx_ready_c), .data_out(data_out_c),
        .tx_active(tx_active_c), .tx_done(tx_done_c));

    // Per-instance views for the randomized run.
    logic [63:0] o_blk [3];
    logic [5:0]  o_flags [3];
    assign o_blk[0]   = rx_block_a;
    assign o_blk[1]   = rx_block_b;
    assign o_blk[2]   = {56'd0, rx_block_c};
    assign o_flags[0] = {rx_valid_a, rx_overrun_a, tx_ready_a, tx_active_a, tx_done_a, data_out_a};
    assign o_flags[1] = {rx_valid_b, rx_overrun_b, tx_ready_b, tx_active_b, tx_done_b, data_out_b};
    assign o_flags[2] = {rx_valid_c, rx_overrun_c, tx_ready_c, tx_active_c, tx_done_c, data_out_c};

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int k = 0; k < 64; k++) r[k] = v[63-k];
        return r;
    endfunction

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic idle_inputs();
        clear = 1'b0; rx_en = 1'b0; data_in = 1'b0; rx_ack = 1'b0; tx_load = 1'b0;
    endtask

    task automatic start();
        idle_inputs();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Drives 64 bits MSB first with rx_en high; optional ack on the last bit.
    task automatic send_word(input logic [63:0] w, input bit ack_last);
        for (int i = 0; i < 64; i++) begin
            rx_en = 1'b1; data_in = w[63-i]; rx_ack = ack_last && (i == 63);
            tick();
        end
        rx_en = 1'b0; rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs(); tx_block = 64'd0;
        n_rst = 1'b1; #1; n_rst = 1'b0; #1;
        checks++; if ({rx_valid_a, rx_overrun_a, data_out_a, tx_active_a, tx_done_a, tx_ready_a} !== 6'b000001) begin
            errors++; $display("FAIL reset_flags_a: got %b expected 000001", {rx_valid_a, rx_overrun_a, data_out_a, tx_active_a, tx_done_a, tx_ready_a}); end
        checks++; if (rx_block_a !== 64'd0) begin errors++; $display("FAIL reset_block_a: got %h expected 0", rx_block_a); end
        checks++; if ({rx_valid_c, tx_ready_c, tx_active_c, rx_block_c} !== {3'b010, 8'h00}) begin
            errors++; $display("FAIL reset_c: got %b expected 01000000000", {rx_valid_c, tx_ready_c, tx_active_c, rx_block_c}); end
        tick(); tick();
        n_rst = 1'b1;
        tick();
        checks++; if ({tx_ready_b, tx_active_b, rx_valid_b} !== 3'b100) begin
            errors++; $display("FAIL reset_release_b: got %b expected 100", {tx_ready_b, tx_active_b, rx_valid_b}); end
    endtask

    task automatic test_rx_msb();
        logic [63:0] w = 64'h0123456789ABCDEF;
        start();
        for (int i = 0; i < 64; i++) begin
            rx_en = 1'b1; data_in = w[63-i];
            tick();
            if (i == 62) begin
                checks++; if (rx_valid_a !== 1'b0) begin errors++; $display("FAIL rx_msb_early: got %b expected 0", rx_valid_a); end
            end
        end
        rx_en = 1'b0;
        checks++; if (rx_valid_a !== 1'b1) begin errors++; $display("FAIL rx_msb_valid: got %b expected 1", rx_valid_a); end
        checks++; if (rx_block_a !== w) begin errors++; $display("FAIL rx_msb_block: got %h expected %h", rx_block_a, w); end
        checks++; if (rx_block_b !== rev64(w)) begin errors++; $display("FAIL rx_lsb_cont_block: got %h expected %h", rx_block_b, rev64(w)); end
        tick();
        checks++; if (rx_valid_a !== 1'b1) begin errors++; $display("FAIL rx_valid_hold: got %b expected 1", rx_valid_a); end
        rx_ack = 1'b1; tick(); rx_ack = 1'b0;
        checks++; if (rx_valid_a !== 1'b0) begin errors++; $display("FAIL rx_ack_clear: got %b expected 0", rx_valid_a); end
    endtask

    task automatic test_rx_lsb_gapped();
        logic [63:0] w = 64'h0123456789ABCDEF;
        start();
        for (int i = 0; i < 64; i++) begin
            rx_en = 1'b1; data_in = w[63-i];
            tick();
            if (i == 62) begin
                checks++; if (rx_valid_b !== 1'b0) begin errors++; $display("FAIL rx_gap_early: got %b expected 0", rx_valid_b); end
            end
            rx_en = 1'b0; data_in = 1'($urandom_range(0, 1));
            tick();
        end
        checks++; if (rx_valid_b !== 1'b1) begin errors++; $display("FAIL rx_gap_valid: got %b expected 1", rx_valid_b); end
        checks++; if (rx_block_b !== 64'hF7B3D591E6A2C480) begin errors++; $display("FAIL rx_gap_block_b: got %h expected f7b3d591e6a2c480", rx_block_b); end
        checks++; if (rx_block_a !== w) begin errors++; $display("FAIL rx_gap_block_a: got %h expected %h", rx_block_a, w); end
    endtask

    task automatic test_overrun();
        logic [63:0] w1, w2, w3;
        w1 = {$urandom, $urandom}; w2 = {$urandom, $urandom}; w3 = {$urandom, $urandom};
        start();
        send_word(w1, 1'b0);
        checks++; if ({rx_valid_a, rx_overrun_a, rx_block_a} !== {2'b10, w1}) begin
            errors++; $display("FAIL ovr_first: got %b %h expected 10 %h", {rx_valid_a, rx_overrun_a}, rx_block_a, w1); end
        send_word(w2, 1'b0);
        checks++; if ({rx_valid_a, rx_overrun_a, rx_block_a} !== {2'b11, w2}) begin
            errors++; $display("FAIL ovr_second: got %b %h expected 11 %h", {rx_valid_a, rx_overrun_a}, rx_block_a, w2); end
        send_word(w3, 1'b1);
        checks++; if ({rx_valid_a, rx_overrun_a, rx_block_a} !== {2'b11, w3}) begin
            errors++; $display("FAIL ovr_third_ack: got %b %h expected 11 %h", {rx_valid_a, rx_overrun_a}, rx_block_a, w3); end
        start();
        checks++; if ({rx_valid_a, rx_overrun_a, rx_block_a} !== {2'b00, w3}) begin
            errors++; $display("FAIL ovr_clear_hold: got %b %h expected 00 %h", {rx_valid_a, rx_overrun_a}, rx_block_a, w3); end
        send_word(w1, 1'b0);
        send_word(w2, 1'b1);
        checks++; if ({rx_valid_a, rx_overrun_a, rx_block_a} !== {2'b10, w2}) begin
            errors++; $display("FAIL ovr_coincident: got %b %h expected 10 %h", {rx_valid_a, rx_overrun_a}, rx_block_a, w2); end
        rx_ack = 1'b1; tick(); tick(); rx_ack = 1'b0;
        send_word(w3, 1'b0);
        checks++; if ({rx_valid_a, rx_overrun_a} !== 2'b10) begin
            errors++; $display("FAIL ovr_after_ack: got %b expected 10", {rx_valid_a, rx_overrun_a}); end
    endtask

    task automatic test_tx_back_to_back();
        logic [63:0] w = 64'hA5A5A5A5A5A5A5A5;
        logic [63:0] w2;
        w2 = {$urandom, $urandom};
        start();
        tx_block = w; tx_load = 1'b1; tick(); tx_load = 1'b0;
        checks++; if ({tx_ready_a, tx_active_a} !== 2'b01) begin errors++; $display("FAIL tx_start: got %b expected 01", {tx_ready_a, tx_active_a}); end
        for (int i = 0; i < 64; i++) begin
            checks++; if ({data_out_a, data_out_b, tx_done_a} !== {w[63-i], w[i], 1'b0}) begin
                errors++; $display("FAIL tx_bit %0d: got %b expected %b", i, {data_out_a, data_out_b, tx_done_a}, {w[63-i], w[i], 1'b0}); end
            // A load while shifting must not disturb the captured word.
            tx_load = (i == 5); if (i == 5) tx_block = ~w;
            tick();
        end
        tx_load = 1'b0;
        checks++; if ({tx_done_a, tx_ready_a, tx_active_a, data_out_a, tx_done_b} !== 5'b11001) begin
            errors++; $display("FAIL tx_done_cycle: got %b expected 11001", {tx_done_a, tx_ready_a, tx_active_a, data_out_a, tx_done_b}); end
        tx_block = w2; tx_load = 1'b1; tick(); tx_load = 1'b0;
        checks++; if ({tx_active_a, tx_done_a, data_out_a, data_out_b} !== {2'b10, w2[63], w2[0]}) begin
            errors++; $display("FAIL tx_b2b_start: got %b expected %b", {tx_active_a, tx_done_a, data_out_a, data_out_b}, {2'b10, w2[63], w2[0]}); end
        for (int i = 1; i < 64; i++) begin
            tick();
            checks++; if (data_out_a !== w2[63-i]) begin errors++; $display("FAIL tx_b2b_bit %0d: got %b expected %b", i, data_out_a, w2[63-i]); end
        end
        tick();
        checks++; if (tx_done_a !== 1'b1) begin errors++; $display("FAIL tx_b2b_done: got %b expected 1", tx_done_a); end
        tick();
        checks++; if ({tx_done_a, tx_ready_a} !== 2'b01) begin errors++; $display("FAIL tx_done_pulse: got %b expected 01", {tx_done_a, tx_ready_a}); end
    endtask

    task automatic test_clear();
        logic [63:0] p, t, q;
        p = {$urandom, $urandom}; t = {$urandom, $urandom}; q = {$urandom, $urandom};
        start();
        send_word(p, 1'b0);
        tx_block = t;
        for (int j = 0; j <= 30; j++) begin
            if (j >= 20) begin
                checks++; if (data_out_a !== t[63-(j-20)]) begin errors++; $display("FAIL clr_tx_bit %0d: got %b expected %b", j - 20, data_out_a, t[63-(j-20)]); end
            end
            rx_en = 1'b1; data_in = 1'($urandom_range(0, 1));
            tx_load = (j == 19) || (j == 30); clear = (j == 30); rx_ack = (j == 30);
            tick();
        end
        idle_inputs();
        checks++; if ({rx_valid_a, rx_overrun_a, data_out_a, tx_active_a, tx_done_a, tx_ready_a} !== 6'b000001) begin
            errors++; $display("FAIL clr_state: got %b expected 000001", {rx_valid_a, rx_overrun_a, data_out_a, tx_active_a, tx_done_a, tx_ready_a}); end
        checks++; if (rx_block_a !== p) begin errors++; $display("FAIL clr_block_hold: got %h expected %h", rx_block_a, p); end
        tick();
        checks++; if ({tx_done_a, tx_active_a} !== 2'b00) begin errors++; $display("FAIL clr_no_done: got %b expected 00", {tx_done_a, tx_active_a}); end
        send_word(q, 1'b0);
        checks++; if ({rx_valid_a, rx_block_a, rx_block_b} !== {1'b1, q, rev64(q)}) begin
            errors++; $display("FAIL clr_clean_block: got %h %h expected %h %h", rx_block_a, rx_block_b, q, rev64(q)); end
    endtask

    task automatic test_async_reset();
        logic [63:0] p, q;
        int seen_done;
        p = {$urandom, $urandom}; q = {$urandom, $urandom};
        start();
        send_word(p, 1'b0);
        tx_block = {$urandom, $urandom}; tx_load = 1'b1; tick(); tx_load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_en = 1'b1; data_in = 1'($urandom_range(0, 1)); tick();
        end
        rx_en = 1'b0;
        #3; n_rst = 1'b0; #1;
        checks++; if ({rx_valid_a, rx_overrun_a, data_out_a, tx_active_a, tx_done_a, tx_ready_a, rx_block_a} !== {6'b000001, 64'd0}) begin
            errors++; $display("FAIL async_reset: got %b %h expected 000001 0", {rx_valid_a, rx_overrun_a, data_out_a, tx_active_a, tx_done_a, tx_ready_a}, rx_block_a); end
        #2; n_rst = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (tx_done_a || tx_active_a) seen_done++;
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL async_no_done: got %0d expected 0", seen_done); end
        send_word(q, 1'b0);
        checks++; if ({rx_valid_a, rx_block_a} !== {1'b1, q}) begin
            errors++; $display("FAIL async_resume: got %h expected %h", rx_block_a, q); end
    endtask

    task automatic test_param8();
        logic [7:0] bits = 8'b10110011;
        start();
        for (int i = 0; i < 8; i++) begin
            rx_en = 1'b1; data_in = bits[7-i]; tick();
        end
        rx_en = 1'b0;
        checks++; if ({rx_valid_c, rx_block_c} !== {1'b1, 8'hB3}) begin
            errors++; $display("FAIL p8_rx: got %b %h expected 1 b3", rx_valid_c, rx_block_c); end
        tx_block = {56'd0, 8'hB3}; tx_load = 1'b1; tick(); tx_load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (data_out_c !== bits[7-i]) begin errors++; $display("FAIL p8_tx_bit %0d: got %b expected %b", i, data_out_c, bits[7-i]); end
            tick();
        end
        checks++; if ({tx_done_c, data_out_c, tx_ready_c} !== 3'b101) begin
            errors++; $display("FAIL p8_tx_done: got %b expected 101", {tx_done_c, data_out_c, tx_ready_c}); end
    endtask

    task automatic test_random();
        logic [63:0] mword [3];
        logic [63:0] mblk [3];
        logic [63:0] tword [3];
        int          mk [3];
        int          tpos [3];
        bit          mval [3], movr [3], mhave [3], tbusy [3], tdone [3];
        int          wd, idx;
        bit          ms, eb;
        logic [5:0]  ef;
        start();
        for (int n = 0; n < 3; n++) begin
            mword[n] = 64'd0; mblk[n] = 64'd0; tword[n] = 64'd0; mk[n] = 0; tpos[n] = 0;
            mval[n] = 1'b0; movr[n] = 1'b0; mhave[n] = 1'b0; tbusy[n] = 1'b0; tdone[n] = 1'b0;
        end
        for (int cyc = 0; cyc < 1200; cyc++) begin
            rx_en    = ($urandom_range(0, 3) != 0);
            data_in  = 1'($urandom_range(0, 1));
            rx_ack   = ($urandom_range(0, 7) == 0);
            tx_load  = ($urandom_range(0, 3) == 0);
            tx_block = {$urandom, $urandom};
            clear    = ($urandom_range(0, 299) == 0);
            for (int n = 0; n < 3; n++) begin
                wd = (n == 2) ? 8 : 64;
                ms = (n != 1);
                if (clear) begin
                    mk[n] = 0; mval[n] = 1'b0; movr[n] = 1'b0; tbusy[n] = 1'b0; tdone[n] = 1'b0;
                end else begin
                    if (rx_en) begin
                        idx = ms ? (wd - 1 - mk[n]) : mk[n];
                        mword[n][idx] = data_in;
                        mk[n]++;
                    end
                    if (mk[n] == wd) begin
                        mk[n] = 0;
                        if (mval[n] && !rx_ack) movr[n] = 1'b1;
                        mval[n] = 1'b1; mblk[n] = mword[n]; mhave[n] = 1'b1;
                    end else if (rx_ack) begin
                        mval[n] = 1'b0;
                    end
                    if (!tbusy[n]) begin
                        tdone[n] = 1'b0;
                        if (tx_load) begin tbusy[n] = 1'b1; tword[n] = tx_block; tpos[n] = 0; end
                    end else begin
                        tpos[n]++;
                        if (tpos[n] == wd) begin tbusy[n] = 1'b0; tdone[n] = 1'b1; end
                    end
                end
            end
            tick();
            for (int n = 0; n < 3; n++) begin
                wd = (n == 2) ? 8 : 64;
                ms = (n != 1);
                if (tbusy[n]) eb = ms ? tword[n][wd-1-tpos[n]] : tword[n][tpos[n]];
                else eb = 1'b0;
                ef = {mval[n], movr[n], !tbusy[n], tbusy[n], tdone[n], eb};
                checks++; if (o_flags[n] !== ef) begin
                    errors++; $display("FAIL rand_flags inst %0d cycle %0d: got %b expected %b", n, cyc, o_flags[n], ef); end
                if (mhave[n]) begin
                    checks++; if (o_blk[n] !== mblk[n]) begin
                        errors++; $display("FAIL rand_block inst %0d cycle %0d: got %h expected %h", n, cyc, o_blk[n], mblk[n]); end
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_rx_msb();
        test_rx_lsb_gapped();
        test_overrun();
        test_tx_back_to_back();
        test_clear();
        test_async_reset();
        test_param8();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
